// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port valid/ready access controller for the shared data
//               memory: arbitrates, legality-checks, runs one access per grant
//               and returns a registered response. Define DMEM_ARB_RR_EN for
//               round-robin arbitration (fixed priority to port 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [2:0]  p0_mask,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [2:0]  p1_mask,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [2:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_gnt;

    logic        w_gnt;
    logic        w_hs;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_we;
    logic [2:0]  w_mask;
    logic        w_illegal;

`ifdef DMEM_ARB_RR_EN
    logic        r_last;

    // On a conflict the port that did not win last time gets the grant.
    assign w_gnt = (p0_req_valid && p1_req_valid) ? ~r_last : p1_req_valid;
`else
    assign w_gnt = ~p0_req_valid;
`endif

    assign p0_req_ready = (r_state == S_IDLE) && p0_req_valid && !w_gnt;
    assign p1_req_ready = (r_state == S_IDLE) && p1_req_valid &&  w_gnt;
    assign w_hs         = p0_req_ready || p1_req_ready;

    assign w_addr  = w_gnt ? p1_addr  : p0_addr;
    assign w_wdata = w_gnt ? p1_wdata : p0_wdata;
    assign w_we    = w_gnt ? p1_we    : p0_we;
    assign w_mask  = w_gnt ? p1_mask  : p0_mask;

    assign w_illegal = (w_mask == 3'b011) || (w_mask == 3'b110) || (w_mask == 3'b111)
                    || (w_we && w_mask[2])
                    || ((w_mask[1:0] == 2'b01) && w_addr[0])
                    || ((w_mask == 3'b010) && (w_addr[1:0] != 2'b00))
                    || (w_addr[31:2] >= c_mem_words);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            r_last       <= 1'b1;
`endif
            p0_rsp_valid <= 1'b0;
            p0_rsp_err   <= 1'b0;
            p0_rsp_rdata <= '0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_err   <= 1'b0;
            p1_rsp_rdata <= '0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            mem_wr       <= 1'b0;
            mem_rd       <= 1'b0;
            mem_mask     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_gnt <= w_gnt;
`ifdef DMEM_ARB_RR_EN
                        r_last <= w_gnt;
`endif
                        if (w_illegal) begin
                            // Rejected requests skip the memory entirely.
                            r_state      <= S_RESP;
                            p0_rsp_valid <= ~w_gnt;
                            p0_rsp_err   <= ~w_gnt;
                            p1_rsp_valid <= w_gnt;
                            p1_rsp_err   <= w_gnt;
                        end else begin
                            r_state     <= S_ACCESS;
                            mem_addr    <= w_addr;
                            mem_wr_data <= w_wdata;
                            mem_mask    <= w_mask;
                            mem_wr      <= w_we;
                            mem_rd      <= ~w_we;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state      <= S_RESP;
                    p0_rsp_valid <= ~r_gnt;
                    p1_rsp_valid <= r_gnt;
                    p0_rsp_rdata <= (!r_gnt && mem_rd) ? mem_rdata : '0;
                    p1_rsp_rdata <= ( r_gnt && mem_rd) ? mem_rdata : '0;
                    mem_addr     <= '0;
                    mem_wr_data  <= '0;
                    mem_wr       <= 1'b0;
                    mem_rd       <= 1'b0;
                    mem_mask     <= '0;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    p0_rsp_valid <= 1'b0;
                    p0_rsp_err   <= 1'b0;
                    p0_rsp_rdata <= '0;
                    p1_rsp_valid <= 1'b0;
                    p1_rsp_err   <= 1'b0;
                    p1_rsp_rdata <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural memory
//               and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid, p0_rsp_err;
    logic        p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
    logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
    logic [2:0]  p0_mask, p1_mask;
    logic [31:0] mem_addr, mem_wr_data, mem_rdata;
    logic        mem_wr, mem_rd;
    logic [2:0]  mem_mask;

    dmem_arbiter #(.MEM_WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_mask(p0_mask),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_mask(p1_mask),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    bit          pv  [2];
    logic [31:0] pa  [2];
    logic [31:0] pw  [2];
    logic        pwe [2];
    logic [2:0]  pm  [2];
    int          last_g;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (m)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                                input logic [2:0] m, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        case (m[1:0])
            2'd0:    r[{off, 3'b000} +: 8] = wd[7:0];
            2'd1:    if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic bit is_legal(input logic [31:0] ad, input logic we, input logic [2:0] m);
        if (m == 3'd3 || m == 3'd6 || m == 3'd7) return 1'b0;
        if (we && m >= 3'd4)                     return 1'b0;
        if ((m == 3'd1 || m == 3'd5) && ad[0])   return 1'b0;
        if (m == 3'd2 && ad[1:0] != 2'b00)       return 1'b0;
        if (ad[31:2] >= 30'd64)                  return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural memory: writes on negedge, combinational read with extraction.
    always @(negedge clk)
        if (mem_wr && mem_addr[31:2] < 30'd64)
            mem[mem_addr[7:2]] <= store_merge(mem[mem_addr[7:2]], mem_addr[1:0], mem_mask, mem_wr_data);

    always_comb begin
        mem_rdata = 32'd0;
        if (mem_addr[31:2] < 30'd64)
            mem_rdata = load_val(mem[mem_addr[7:2]], mem_addr[1:0], mem_mask);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_inputs();
        p0_req_valid = pv[0]; p0_addr = pa[0]; p0_wdata = pw[0]; p0_we = pwe[0]; p0_mask = pm[0];
        p1_req_valid = pv[1]; p1_addr = pa[1]; p1_wdata = pw[1]; p1_we = pwe[1]; p1_mask = pm[1];
    endtask

    task automatic set_req(input int p, input logic [31:0] ad, input logic [31:0] wd,
                           input logic we, input logic [2:0] m);
        pv[p] = 1'b1; pa[p] = ad; pw[p] = wd; pwe[p] = we; pm[p] = m;
    endtask

    task automatic rand_payload(input int p);
        pwe[p] = 1'($urandom_range(0, 1));
        pm[p]  = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'd4 : 3'd0)
                                            : 3'($urandom_range(0, 7));
        pa[p]  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 255)) : $urandom;
        pw[p]  = $urandom;
    endtask

    // One full transaction from the IDLE cycle through the cycle after the response.
    task automatic do_txn(input bit keep);
        int          g;
        bit          ok;
        logic [31:0] ad, wd, exp_rd, rd;
        logic [2:0]  mk;
        logic        we;
        apply_inputs();
        #1;
        if (pv[0] && pv[1]) g = (c_rr && last_g == 0) ? 1 : 0;
        else                g = pv[1] ? 1 : 0;
        chk("idle_ready", {30'd0, p1_req_ready, p0_req_ready}, (g == 1) ? 32'd2 : 32'd1);
        ad = pa[g]; wd = pw[g]; we = pwe[g]; mk = pm[g];
        ok = is_legal(ad, we, mk);
        exp_rd = 32'd0;
        if (ok && !we) exp_rd = load_val(ref_mem[ad[7:2]], ad[1:0], mk);
        if (ok && we)  ref_mem[ad[7:2]] = store_merge(ref_mem[ad[7:2]], ad[1:0], mk, wd);
        last_g = g;
        step();
        if (!keep) begin
            pv[0] = 1'b0; pv[1] = 1'b0;
            rand_payload(0); rand_payload(1);
            apply_inputs();
        end
        #1;
        chk("busy_ready", {30'd0, p1_req_ready, p0_req_ready}, 32'd0);
        if (ok) begin
            chk("acc_wr", {31'd0, mem_wr}, {31'd0, we});
            chk("acc_rd", {31'd0, mem_rd}, {31'd0, !we});
            chk("acc_addr", mem_addr, ad);
            chk("acc_mask", {29'd0, mem_mask}, {29'd0, mk});
            chk("acc_wdata", mem_wr_data, wd);
            chk("acc_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
            step();
        end else begin
            chk("ill_mem", {30'd0, mem_wr, mem_rd}, 32'd0);
        end
        chk("rsp_valid", {30'd0, p1_rsp_valid, p0_rsp_valid}, (g == 1) ? 32'd2 : 32'd1);
        chk("rsp_err", {31'd0, (g == 1) ? p1_rsp_err : p0_rsp_err}, {31'd0, !ok});
        rd = (g == 1) ? p1_rsp_rdata : p0_rsp_rdata;
        chk("rsp_rdata", rd, exp_rd);
        last_rd = rd;
        chk("rsp_mem", {30'd0, mem_wr, mem_rd}, 32'd0);
        chk("rsp_ready", {30'd0, p1_req_ready, p0_req_ready}, 32'd0);
        step();
        chk("post_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pa[p] = '0; pw[p] = '0; pwe[p] = 1'b0; pm[p] = '0;
        end
        last_g  = 1;
        last_rd = '0;
        rst_n   = 1'b0;
        apply_inputs();
        #1;
        chk("rst_mem", {mem_addr | mem_wr_data, 27'd0, mem_wr, mem_rd, mem_mask} , 64'd0);
        chk("rst_rsp", {26'd0, p1_rsp_valid, p1_rsp_err, p0_rsp_valid, p0_rsp_err,
                        p1_req_ready, p0_req_ready}, 32'd0);
        chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Directed: store/load word on port 0.
        set_req(0, 32'h10, 32'hDEADBEEF, 1'b1, 3'b010); do_txn(1'b0);
        set_req(0, 32'h10, 32'h0, 1'b0, 3'b010);        do_txn(1'b0);
        chk("tp_lw", last_rd, 32'hDEADBEEF);

        // Directed: sign-extended byte load on port 1.
        set_req(0, 32'h10, 32'h000080FF, 1'b1, 3'b010); do_txn(1'b0);
        set_req(1, 32'h11, 32'h0, 1'b0, 3'b000);        do_txn(1'b0);
        chk("tp_lb", last_rd, 32'hFFFFFF80);

        // Directed: illegal requests.
        set_req(0, 32'h02, 32'h0, 1'b0, 3'b010);  do_txn(1'b0);
        set_req(0, 32'h20, 32'h5A, 1'b1, 3'b100); do_txn(1'b0);
        set_req(1, 32'h100, 32'h0, 1'b0, 3'b010); do_txn(1'b0);

        // Both ports requesting continuously.
        set_req(0, 32'h40, 32'h0, 1'b0, 3'b010);
        set_req(1, 32'h44, 32'h0, 1'b0, 3'b010);
        for (int i = 0; i < 6; i++) do_txn(1'b1);
        pv[0] = 1'b0; pv[1] = 1'b0; apply_inputs();

        // Reset during the ACCESS cycle of a port-0 load.
        set_req(0, 32'h18, 32'h0, 1'b0, 3'b010); pv[1] = 1'b0;
        apply_inputs();
        #1;
        chk("ra_ready", {31'd0, p0_req_ready}, 32'd1);
        step();
        pv[0] = 1'b0; apply_inputs();
        #1;
        chk("ra_acc_rd", {31'd0, mem_rd}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_mem", {mem_addr, 27'd0, mem_wr, mem_rd, mem_mask}, 64'd0);
        chk("ra_rsp", {28'd0, p1_rsp_valid, p1_rsp_err, p0_rsp_valid, p0_rsp_err}, 32'd0);
        step();
        chk("ra_hold", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        last_g = 1;
        step();
        chk("ra_norsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
        set_req(1, 32'h18, 32'h0, 1'b0, 3'b010); do_txn(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            rand_payload(0); rand_payload(1);
            pv[0] = 1'($urandom_range(0, 1));
            pv[1] = 1'($urandom_range(0, 1));
            if (!pv[0] && !pv[1]) pv[$urandom_range(0, 1)] = 1'b1;
            do_txn(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port access controller that shares the single data memory between the core load/store unit (port 0) and the debug/loader port (port 1). It runs a valid/ready request handshake, arbitrates, and checks each request for legal mask, alignment and range. It then sequences one memory access per grant and returns a registered response to the winning requester. It sits between the requesters and the memory's addr/wr_data/mem_wr/mem_rd/mask/dmem_o pins.

## Interface
- MEM_WORDS, 64: number of 32-bit words in data memory; word index `addr[31:2]` ≥ MEM_WORDS is out of range.
- clk  in  1  system clock; memory writes on its negedge.
- rst_n  in  1  asynchronous, active-low reset.
- pN_req_valid  in  1  port N request (N = 0, 1).
- pN_req_ready  out  1  port N request accepted this cycle when valid & ready.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  store data, right-aligned.
- pN_we  in  1  1 = store, 0 = load.
- pN_mask  in  3  funct3 access code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- pN_rsp_valid  out  1  one-cycle response pulse; no backpressure.
- pN_rsp_rdata  out  32  load result; 0 for stores and errors.
- pN_rsp_err  out  1  request rejected; qualified by rsp_valid.
- mem_addr  out  32  to memory addr.
- mem_wr_data  out  32  to memory wr_data.
- mem_wr  out  1  memory write enable.
- mem_rd  out  1  memory read enable.
- mem_mask  out  3  to memory mask.
- mem_rdata  in  32  memory combinational read data (dmem_o).

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - pN_req_ready = 1 for the port the arbiter would grant this cycle; 0 for the other.
  - On handshake, latch addr, wdata, we, mask and grant id.
  - Go to ACCESS if the request is legal; go to RESP with err = 1 if illegal.
- Illegal request is any of:
  - mask ∈ {011, 110, 111};
  - store with mask[2] = 1;
  - mask 001/101 with addr[0] = 1;
  - mask 010 with addr[1:0] ≠ 00;
  - addr[31:2] ≥ MEM_WORDS.
- An illegal request never asserts mem_wr or mem_rd.
- ACCESS:
  - Drive mem_* from the latched request for exactly one full clk cycle.
  - mem_rd = ~we, mem_wr = we.
  - For loads, register mem_rdata into the response register at the ACCESS→RESP edge.
  - Go to RESP.
- RESP:
  - Assert rsp_valid for the granted port only, for one cycle.
  - rdata is the registered value for loads, 0 for stores and errors.
  - Go to IDLE.
- Outside ACCESS: mem_wr = mem_rd = 0 and mem_addr, mem_wr_data, mem_mask = 0.
- Arbitration: see Configuration.
- Only one request is outstanding at a time; both req_ready signals are 0 in ACCESS and RESP.

## Timing
- Reset values:
  - state = IDLE;
  - all pN_req_ready, pN_rsp_valid, pN_rsp_err = 0;
  - pN_rsp_rdata = 0;
  - all mem_* outputs = 0;
  - last-grant register = 1.
- Handshake at edge T → ACCESS during cycle T+1 → rsp_valid during cycle T+2.
- Illegal request: handshake at T → rsp_valid with err = 1 during cycle T+1.
- Throughput: one legal access per 3 cycles; one illegal request per 2 cycles.
- req_ready is combinational from req_valid and arbitration state in IDLE.
- All other outputs are registered.
- Requesters may change valid and payload freely until the handshake; unaccepted requests are not latched.
- Reset asserted mid-ACCESS:
  - mem_wr and mem_rd drop immediately (asynchronous);
  - no response is issued;
  - a store in flight may or may not have committed.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - When both ports request in IDLE, grant the port not in the last-grant register.
  - Update the last-grant register on every handshake.
  - After reset, port 0 wins the first conflict.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins.
  - The last-grant register is not implemented.
  - Port 1 can starve.
- Single-requester behaviour is identical in both builds.

## Test plan
- Port 0 only, SW addr 0x10 wdata 0xDEADBEEF, then LW addr 0x10:
  - store: mem_wr = 1 for one cycle with mem_addr 0x10;
  - load: p0_rsp_valid at T+2 with rdata 0xDEADBEEF, err = 0.
- Port 1 LB addr 0x11 with memory word 4 = 0x0000_80FF: mem_mask 000, mem_addr 0x11 during ACCESS; p1_rsp_rdata = memory output 0xFFFFFF80.
- Illegal requests: p0 LW addr 0x02, p0 SB mask 100, p1 LW addr 0x100 (word 64):
  - each gets rsp_err = 1 at T+1;
  - mem_wr and mem_rd never assert.
- Both ports valid continuously for 6 grants:
  - RR build grants 0,1,0,1,0,1;
  - non-RR build grants 0 six times, with p1_req_ready held 0.
- Assert rst_n low during ACCESS of a load on port 0:
  - all outputs 0 immediately, no rsp_valid;
  - after release, a new p1 request completes normally with T+2 latency.
